// File: rtl/invaders_pkg.sv
// Playfield geometry and state encoding shared by the invaders game blocks.
package invaders_pkg;

  localparam int ALIEN_W   = 30;
  localparam int ALIEN_H   = 20;
  localparam int COL_PITCH = 40;
  localparam int ROW_PITCH = 30;
  localparam int NUM_COLS  = 10;
  localparam int NUM_ROWS  = 5;
  localparam int PLAYER_W  = 30;
  localparam int PLAYER_H  = 20;
  localparam int SHOT_W    = 4;
  localparam int SHOT_H    = 8;
  localparam int SCREEN_H  = 480;
  localparam int PARK_ROW  = 500;

  typedef enum logic [1:0] {
    ST_COOLDOWN,
    ST_SELECT,
    ST_FLIGHT,
    ST_GAMEOVER
  } alien_shot_state_t;

endpackage

// File: rtl/alien_shot_if.sv
// Formation/player inputs and shot/lives outputs of the enemy-fire engine.
interface alien_shot_if;

  logic        Move_En;
  logic [8:0]  Aliens_Row;
  logic [9:0]  Aliens_Col;
  logic [49:0] Aliens_Grid;
  logic [8:0]  Player_Row;
  logic [9:0]  Player_Col;
  logic [8:0]  Shot_Row;
  logic [9:0]  Shot_Col;
  logic        Shot_Onscreen;
  logic        Player_Hit;
  logic [1:0]  Lives;
  logic        Game_Over;

  modport master (
    output Move_En, Aliens_Row, Aliens_Col, Aliens_Grid, Player_Row, Player_Col,
    input  Shot_Row, Shot_Col, Shot_Onscreen, Player_Hit, Lives, Game_Over
  );

  modport slave (
    input  Move_En, Aliens_Row, Aliens_Col, Aliens_Grid, Player_Row, Player_Col,
    output Shot_Row, Shot_Col, Shot_Onscreen, Player_Hit, Lives, Game_Over
  );

endinterface

// File: rtl/alien_shot_lfsr10.sv
// Free-running 10-bit Fibonacci LFSR, polynomial x^10+x^7+1, seeded with 10'h2A5.
module lfsr10 (
  input  logic       Clk,
  input  logic       Reset,
  output logic [9:0] q
);

  always_ff @(posedge Clk) begin
    if (Reset) q <= 10'h2A5;
    else       q <= {q[8:0], q[9] ^ q[6]};
  end

endmodule

// File: rtl/alien_shot.sv
// Enemy-fire engine: picks a column, fires from its lowest alien, flies the shot and scores hits.
module alien_shot
  import invaders_pkg::*;
#(
  parameter int FIRE_DELAY  = 16,
  parameter int SHOT_STEP   = 8,
  parameter int START_LIVES = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  alien_shot_if.slave  bus
);

  alien_shot_state_t state;
  logic [15:0] cnt;
  logic [3:0]  col;
  logic [3:0]  tries;
  logic [8:0]  shot_row;
  logic [9:0]  shot_col;
  logic        onscreen;
  logic        hit_q;
  logic [1:0]  lives;
  logic        game_over;

  logic [9:0] lfsr_q;
  logic       unused_lfsr;
  logic [3:0] col_init;

  lfsr10 u_lfsr (.Clk(Clk), .Reset(Reset), .q(lfsr_q));

  assign unused_lfsr = ^lfsr_q[9:4];
  assign col_init    = (lfsr_q[3:0] >= 4'd10) ? lfsr_q[3:0] - 4'd10 : lfsr_q[3:0];

  logic [NUM_ROWS-1:0] col_bits;
  logic                found;
  logic [2:0]          sel_r;
  logic [9:0]          sel_col_px;
  logic [8:0]          sel_row_px;
  logic                hit_now;
  logic [9:0]          step_row;

  always_comb begin
    found = 1'b0;
    sel_r = 3'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      col_bits[r] = bus.Aliens_Grid[r*NUM_COLS + int'(col)];
      // ascending scan: the last live row wins, i.e. the lowest alien on screen
      if (col_bits[r]) begin
        found = 1'b1;
        sel_r = 3'(r);
      end
    end
    sel_col_px = 10'(int'(bus.Aliens_Col) + COL_PITCH*int'(col) + (ALIEN_W - SHOT_W)/2);
    sel_row_px = 9'(int'(bus.Aliens_Row) + ROW_PITCH*int'(sel_r) + ALIEN_H);
    hit_now = (int'(shot_col) + SHOT_W > int'(bus.Player_Col)) &&
              (int'(shot_col) < int'(bus.Player_Col) + PLAYER_W) &&
              (int'(shot_row) + SHOT_H > int'(bus.Player_Row)) &&
              (int'(shot_row) < int'(bus.Player_Row) + PLAYER_H);
    step_row = {1'b0, shot_row} + 10'(SHOT_STEP);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_COOLDOWN;
      cnt       <= '0;
      col       <= '0;
      tries     <= '0;
      shot_row  <= 9'(PARK_ROW);
      shot_col  <= '0;
      onscreen  <= 1'b0;
      hit_q     <= 1'b0;
      lives     <= 2'(START_LIVES);
      game_over <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state)
        ST_COOLDOWN: begin
          if (bus.Move_En) begin
            if (cnt == 16'(FIRE_DELAY - 1)) begin
              cnt   <= '0;
              col   <= col_init;
              tries <= '0;
              state <= ST_SELECT;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        ST_SELECT: begin
          if (found) begin
            shot_col <= sel_col_px;
            shot_row <= sel_row_px;
            onscreen <= 1'b1;
            state    <= ST_FLIGHT;
          end else if (tries == 4'(NUM_COLS - 1)) begin
            state <= ST_COOLDOWN;
          end else begin
            col   <= (col == 4'(NUM_COLS - 1)) ? 4'd0 : col + 4'd1;
            tries <= tries + 4'd1;
          end
        end
        ST_FLIGHT: begin
          // a hit outranks a same-cycle step
          if (hit_now) begin
            hit_q    <= 1'b1;
            onscreen <= 1'b0;
            shot_row <= 9'(PARK_ROW);
            shot_col <= '0;
            if (lives <= 2'd1) begin
              lives     <= 2'd0;
              game_over <= 1'b1;
              state     <= ST_GAMEOVER;
            end else begin
              lives <= lives - 2'd1;
              state <= ST_COOLDOWN;
            end
          end else if (bus.Move_En) begin
            if (step_row >= 10'(SCREEN_H)) begin
              onscreen <= 1'b0;
              shot_row <= 9'(PARK_ROW);
              shot_col <= '0;
              state    <= ST_COOLDOWN;
            end else begin
              shot_row <= step_row[8:0];
            end
          end
        end
        ST_GAMEOVER: begin
          game_over <= 1'b1;
          lives     <= 2'd0;
          onscreen  <= 1'b0;
          shot_row  <= 9'(PARK_ROW);
          shot_col  <= '0;
        end
        default: state <= ST_COOLDOWN;
      endcase
    end
  end

  assign bus.Shot_Row      = shot_row;
  assign bus.Shot_Col      = shot_col;
  assign bus.Shot_Onscreen = onscreen;
  assign bus.Player_Hit    = hit_q;
  assign bus.Lives         = lives;
  assign bus.Game_Over     = game_over;

endmodule

// File: doc/alien_shot.md
# alien_shot

Enemy-fire engine for the invaders playfield: the downward counterpart of the player bullet. It periodically picks a pseudo-random column of the alien formation and fires one shot from the lowest surviving alien in that column. It moves the shot down the screen, detects hits on the player, and maintains the player's lives and game-over flag. It sits beside the player-bullet block, consuming the same formation position and alive grid, and feeds the renderer and game-control logic.

## Interface
Parameters:
- FIRE_DELAY, 16: Move_En strobes spent in COOLDOWN between shots.
- SHOT_STEP, 8: pixels the shot descends per Move_En.
- START_LIVES, 3: lives loaded on reset; must be 1..3.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high.
- Move_En  in  1  one-cycle frame/motion strobe.
- Aliens_Row  in  9  top pixel row of the formation.
- Aliens_Col  in  10  left pixel column of the formation.
- Aliens_Grid  in  50  alive map; bit r*10+c is the alien at row r (0..4) and column c (0..9).
- Player_Row  in  9  top pixel row of the player.
- Player_Col  in  10  left pixel column of the player.
- Shot_Row  out  9  top row of the shot; 500 when parked.
- Shot_Col  out  10  left column of the shot; 0 when parked.
- Shot_Onscreen  out  1  high while in FLIGHT.
- Player_Hit  out  1  one-cycle pulse on a hit.
- Lives  out  2  remaining lives.
- Game_Over  out  1  sticky until Reset.

## Operation
- States are COOLDOWN, SELECT, FLIGHT and GAMEOVER.
- Reset puts the block in COOLDOWN:
  - cooldown counter = 0;
  - Shot_Row = 500, Shot_Col = 0;
  - Player_Hit = 0, Game_Over = 0;
  - Lives = START_LIVES;
  - LFSR = 10'h2A5.
- LFSR: 10-bit Fibonacci, polynomial x^10+x^7+1. It advances every cycle except during Reset.
- COOLDOWN:
  - Each Move_En increments the counter.
  - On the Move_En that takes the counter to FIRE_DELAY: clear the counter, set col = LFSR[3:0] mod 10 and tries = 0, go to SELECT.
- SELECT (one column per cycle):
  - Find the highest r with Aliens_Grid[r*10+col] = 1.
  - If found, load Shot_Col = Aliens_Col + 40*col + 13 and Shot_Row = Aliens_Row + 30*r + 20, then go to FLIGHT.
  - If not found, col = (col+1) mod 10 and tries++.
  - After 10 empty columns, return to COOLDOWN with no shot.
  - Move_En is ignored in SELECT.
- FLIGHT, checked every cycle against the current registers:
  - Hit test: overlap of the 4x8 shot box with the 30x20 player box. All four must hold: Shot_Col+4 > Player_Col; Shot_Col < Player_Col+30; Shot_Row+8 > Player_Row; Shot_Row < Player_Row+20.
  - On hit: pulse Player_Hit, Lives−1, park the shot. Go to GAMEOVER if the new Lives = 0, else COOLDOWN.
  - Otherwise, on Move_En: Shot_Row += SHOT_STEP (compute in 10 bits). If the result is ≥ 480, park and go to COOLDOWN.
- GAMEOVER: Game_Over = 1, shot parked, Lives = 0. Held until Reset.
- Arithmetic:
  - Row sums use 10-bit intermediates. The 9-bit Shot_Row never exceeds 487 before parking.
  - Column math is 10-bit; overflow is impossible for legal formation positions.

## Timing
- Shot_Onscreen rises 1–10 cycles after the triggering Move_En (one cycle per SELECT column examined).
- Player_Hit asserts on the cycle after Shot_Row first overlaps the player; it is high for exactly one cycle.
- Shot_Onscreen falls and Lives updates on that same edge.
- A hit and a Move_En in the same cycle: the hit wins and no step is applied.
- Aliens_Grid or formation changes during FLIGHT do not affect the shot in flight. The grid is sampled only in SELECT.
- Reset mid-FLIGHT or mid-SELECT: reset values on the next edge, and any pending hit is discarded.
- Lives never wraps below 0.

## Structure
- Shared package invaders_pkg holds the constants and the state enum:
  - ALIEN_W = 30, ALIEN_H = 20;
  - COL_PITCH = 40, ROW_PITCH = 30;
  - NUM_COLS = 10, NUM_ROWS = 5;
  - PLAYER_W = 30, PLAYER_H = 20;
  - SHOT_W = 4, SHOT_H = 8;
  - SCREEN_H = 480, PARK_ROW = 500;
  - the enum alien_shot_state_t.
- One sub-module, lfsr10 (Clk, Reset, q[9:0]), reused later for other random events.

## Test plan
- Reset → Lives = 3, Shot_Row = 500, Shot_Col = 0, Game_Over = 0, Shot_Onscreen = 0. With no Move_En, no shot appears for 1000 cycles.
- Set Aliens_Row = 40, Aliens_Col = 100, grid = only bit 13 (r = 1, c = 3). After the 16th Move_En → Shot_Col = 233, Shot_Row = 90, Shot_Onscreen = 1 within 10 cycles.
- Same setup, player at (440, 220). Shot steps 90, 98, …, reaching 434 → one-cycle Player_Hit, Lives 3→2, Shot_Row = 500.
- Same setup, player at column 400 → shot reaches 482 → parked, no Player_Hit, Lives stays 3, next shot after 16 more Move_En.
- Three consecutive hits → Lives = 0, Game_Over = 1. No further shots for 100 Move_En; Reset restores Lives = 3.
- Aliens_Grid = 0 → 10 SELECT cycles, return to COOLDOWN, Shot_Onscreen stays 0. Assert Reset during FLIGHT → parked on the next edge.
